// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: sizes, aligns and (optionally) splits loads/stores
// into one or two aligned memory beats, then returns an extended load result.
module dm_access_ctrl #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter bit          ALLOW_MISALIGN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_size,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                mem_en,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(BYTES);
  localparam int unsigned NB_W   = OFF_W + 1;
  localparam int unsigned NBX_W  = NB_W + 1;
  localparam int unsigned SH_W   = OFF_W + 3;
  localparam int unsigned STRB_W = 2 * BYTES;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  state_t state, state_nxt;

  logic              accept;
  logic [NB_W-1:0]   in_nbytes;
  logic [OFF_W-1:0]  in_off;
  logic              in_illegal, in_misalign, in_split, in_err;

  logic              r_we, r_split, r_err;
  logic [2:0]        r_size;
  logic [NB_W-1:0]   r_nbytes;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_beat0;

  logic [OFF_W-1:0]  r_off;
  logic [SH_W-1:0]   r_sh;
  logic [ADDR_W-1:0] base_addr, next_addr;
  logic [STRB_W-1:0] strb;
  logic [DATA_W-1:0] wdata_rot, ld, ld_ext;

  // Request decode: byte count and legality of the incoming access
  always_comb begin
    in_nbytes  = NB_W'(4);
    in_illegal = 1'b0;
    case (req_size)
      3'b000:         in_nbytes = NB_W'(4);
      3'b001, 3'b010: in_nbytes = NB_W'(2);
      3'b011, 3'b100: in_nbytes = NB_W'(1);
      3'b101: begin
        in_nbytes  = NB_W'(BYTES);
        in_illegal = (DATA_W != 64);
      end
      default:        in_illegal = 1'b1;
    endcase
  end

  assign in_off      = req_addr[OFF_W-1:0];
  assign in_misalign = |(NB_W'(in_off) & (in_nbytes - NB_W'(1)));
  assign in_err      = in_illegal | (in_misalign & !ALLOW_MISALIGN);
  assign in_split    = (NBX_W'(in_off) + NBX_W'(in_nbytes)) > NBX_W'(BYTES);
  assign accept      = req_valid & (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Captured request plus beat-0 read data for split loads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_split  <= 1'b0;
      r_err    <= 1'b0;
      r_size   <= '0;
      r_nbytes <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_beat0  <= '0;
    end else begin
      if (accept) begin
        r_we     <= req_we;
        r_size   <= req_size;
        r_nbytes <= in_nbytes;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_err    <= in_err;
        r_split  <= in_split & ~in_err;
      end
      if (state == ACC1) r_beat0 <= mem_rdata;
    end
  end

  assign r_off     = r_addr[OFF_W-1:0];
  assign r_sh      = {r_off, 3'b000};
  assign base_addr = {r_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
  assign next_addr = base_addr + ADDR_W'(BYTES);
  assign strb      = ((STRB_W'(1) << r_nbytes) - STRB_W'(1)) << r_off;
  // Rotate left so operand byte k lands on lane (offset+k) mod BYTES
  assign wdata_rot = DATA_W'(({r_wdata, r_wdata} << r_sh) >> DATA_W);
  assign ld        = DATA_W'({mem_rdata, (r_split ? r_beat0 : mem_rdata)} >> r_sh);

  always_comb begin
    ld_ext = ld;
    case (r_size)
      3'b000:  ld_ext = DATA_W'(ld[31:0]);
      3'b001:  ld_ext = DATA_W'($signed(ld[15:0]));
      3'b010:  ld_ext = DATA_W'(ld[15:0]);
      3'b011:  ld_ext = DATA_W'($signed(ld[7:0]));
      3'b100:  ld_ext = DATA_W'(ld[7:0]);
      default: ld_ext = ld;
    endcase
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_en     = 1'b0;
    mem_addr   = '0;
    mem_we     = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = in_err ? DONE : ACC0;
      end
      ACC0: begin
        mem_en   = 1'b1;
        mem_addr = base_addr;
        if (r_we) begin
          mem_we    = strb[BYTES-1:0];
          mem_wdata = wdata_rot;
        end
        state_nxt = r_split ? ACC1 : DONE;
      end
      ACC1: begin
        mem_en   = 1'b1;
        mem_addr = next_addr;
        if (r_we) begin
          mem_we    = strb[STRB_W-1:BYTES];
          mem_wdata = wdata_rot;
        end
        state_nxt = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        if (!r_we && !r_err) resp_rdata = ld_ext;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl: 32-bit misalign-split, 32-bit misalign-error
// and 64-bit instances, each backed by a shared byte-addressed memory model.
module tb_dm_access_ctrl;

  typedef struct {
    int          cyc;
    logic [63:0] addr;
    logic [7:0]  we;
    logic [63:0] wdata;
  } beat_t;

  typedef struct {
    int          cyc;
    logic        err;
    logic [63:0] rdata;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  beat_t exp_beat [3][$];
  resp_t exp_resp [3][$];
  logic [7:0] mem [bit [31:0]];

  logic [2:0]  req_valid = '0;
  logic        req_we = 1'b0;
  logic [2:0]  req_size = '0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;

  logic        a_ready, a_rv, a_err, a_en;
  logic [31:0] a_rdata, a_addr, a_wdata;
  logic [3:0]  a_we;
  logic [31:0] rd_a = '0;

  logic        b_ready, b_rv, b_err, b_en;
  logic [31:0] b_rdata, b_addr, b_wdata;
  logic [3:0]  b_we;
  logic [31:0] rd_b = '0;

  logic        c_ready, c_rv, c_err, c_en;
  logic [63:0] c_rdata, c_wdata;
  logic [31:0] c_addr;
  logic [7:0]  c_we;
  logic [63:0] rd_c = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_access_ctrl #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGN(1'b1)) u_a (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(a_ready),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .resp_valid(a_rv), .resp_rdata(a_rdata), .resp_err(a_err),
    .mem_en(a_en), .mem_addr(a_addr), .mem_we(a_we), .mem_wdata(a_wdata), .mem_rdata(rd_a)
  );

  dm_access_ctrl #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGN(1'b0)) u_b (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(b_ready),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .resp_valid(b_rv), .resp_rdata(b_rdata), .resp_err(b_err),
    .mem_en(b_en), .mem_addr(b_addr), .mem_we(b_we), .mem_wdata(b_wdata), .mem_rdata(rd_b)
  );

  dm_access_ctrl #(.DATA_W(64), .ADDR_W(32), .ALLOW_MISALIGN(1'b1)) u_c (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(c_ready),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(c_rv), .resp_rdata(c_rdata), .resp_err(c_err),
    .mem_en(c_en), .mem_addr(c_addr), .mem_we(c_we), .mem_wdata(c_wdata), .mem_rdata(rd_c)
  );

  function automatic logic [63:0] rdm(input logic [31:0] a, input int n);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++)
      if (mem.exists(a + 32'(i))) r[8*i +: 8] = mem[a + 32'(i)];
    return r;
  endfunction

  // Memory model: read data one cycle after a read strobe, byte-lane writes
  always @(posedge clk) begin
    if (a_en) begin
      if (a_we == 4'd0) rd_a <= 32'(rdm(a_addr, 4));
      for (int i = 0; i < 4; i++) if (a_we[i]) mem[a_addr + 32'(i)] = a_wdata[8*i +: 8];
    end
    if (b_en) begin
      if (b_we == 4'd0) rd_b <= 32'(rdm(b_addr, 4));
      for (int i = 0; i < 4; i++) if (b_we[i]) mem[b_addr + 32'(i)] = b_wdata[8*i +: 8];
    end
    if (c_en) begin
      if (c_we == 8'd0) rd_c <= rdm(c_addr, 8);
      for (int i = 0; i < 8; i++) if (c_we[i]) mem[c_addr + 32'(i)] = c_wdata[8*i +: 8];
    end
  end

  task automatic check(input int d, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL dut%0d %s: got 0x%0h, expected 0x%0h (cycle %0d)", d, name, act, exp, cyc);
    end
  endtask

  function automatic logic rdy(input int d);
    case (d)
      0:       return a_ready;
      1:       return b_ready;
      default: return c_ready;
    endcase
  endfunction

  task automatic mon(input int d, input logic en, input logic [63:0] addr, input logic [7:0] we,
                     input logic [63:0] wdata, input logic rv, input logic err, input logic [63:0] rdata);
    beat_t b;
    resp_t r;
    logic [63:0] m;
    if (en) begin
      if (exp_beat[d].size() == 0) check(d, "unexpected_mem_en", 64'(en), 64'd0);
      else begin
        b = exp_beat[d].pop_front();
        check(d, "beat_cycle", 64'(cyc), 64'(b.cyc));
        check(d, "mem_addr", addr, b.addr);
        check(d, "mem_we", 64'(we), 64'(b.we));
        if (b.we != 8'd0) begin
          m = '0;
          for (int i = 0; i < 8; i++) if (b.we[i]) m[8*i +: 8] = 8'hFF;
          check(d, "mem_wdata", wdata & m, b.wdata & m);
        end
      end
    end else begin
      check(d, "mem_we_idle", 64'(we), 64'd0);
    end
    if (rv) begin
      if (exp_resp[d].size() == 0) check(d, "unexpected_resp", 64'(rv), 64'd0);
      else begin
        r = exp_resp[d].pop_front();
        check(d, "resp_cycle", 64'(cyc), 64'(r.cyc));
        check(d, "resp_err", 64'(err), 64'(r.err));
        check(d, "resp_rdata", rdata, r.rdata);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, a_en, 64'(a_addr), 8'(a_we), 64'(a_wdata), a_rv, a_err, 64'(a_rdata));
      mon(1, b_en, 64'(b_addr), 8'(b_we), 64'(b_wdata), b_rv, b_err, 64'(b_rdata));
      mon(2, c_en, 64'(c_addr), c_we, c_wdata, c_rv, c_err, c_rdata);
    end
  end

  task automatic pb(input int d, input int c, input logic [63:0] addr, input logic [7:0] we, input logic [63:0] wdata);
    beat_t b;
    b.cyc = c; b.addr = addr; b.we = we; b.wdata = wdata;
    exp_beat[d].push_back(b);
  endtask

  task automatic pr(input int d, input int c, input logic err, input logic [63:0] rdata);
    resp_t r;
    r.cyc = c; r.err = err; r.rdata = rdata;
    exp_resp[d].push_back(r);
  endtask

  // Present a request while the DUT is idle; t is the acceptance cycle
  task automatic issue(input int d, input logic we, input logic [2:0] size, input logic [31:0] addr,
                       input logic [63:0] wdata, output int t);
    req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    req_valid[d] = 1'b1;
    check(d, "req_ready", 64'(rdy(d)), 64'd1);
    t = cyc;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int k = 0;
    while ((exp_beat[d].size() != 0 || exp_resp[d].size() != 0) && k < 12) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_checks++;
    if (exp_beat[d].size() != 0 || exp_resp[d].size() != 0) begin
      n_fail++;
      $display("FAIL dut%0d timeout: %0d beats and %0d responses still pending", d,
               exp_beat[d].size(), exp_resp[d].size());
      exp_beat[d].delete();
      exp_resp[d].delete();
    end
    @(negedge clk);
    #1;
  endtask

  task automatic chk_rst(input int d, input logic ready, input logic rv, input logic err, input logic en,
                         input logic [63:0] addr, input logic [7:0] we, input logic [63:0] wdata,
                         input logic [63:0] rdata);
    check(d, "rst_ready", 64'(ready), 64'd1);
    check(d, "rst_resp_valid", 64'(rv), 64'd0);
    check(d, "rst_resp_err", 64'(err), 64'd0);
    check(d, "rst_mem_en", 64'(en), 64'd0);
    check(d, "rst_mem_addr", addr, 64'd0);
    check(d, "rst_mem_we", 64'(we), 64'd0);
    check(d, "rst_mem_wdata", wdata, 64'd0);
    check(d, "rst_resp_rdata", rdata, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    mem[32'h100] = 8'h34; mem[32'h101] = 8'h12; mem[32'h102] = 8'hFF; mem[32'h103] = 8'h80;
    for (int i = 0; i < 16; i++) mem[32'h8 + 32'(i)] = 8'(8'h10 + i);

    repeat (2) @(negedge clk);
    chk_rst(0, a_ready, a_rv, a_err, a_en, 64'(a_addr), 8'(a_we), 64'(a_wdata), 64'(a_rdata));
    chk_rst(1, b_ready, b_rv, b_err, b_en, 64'(b_addr), 8'(b_we), 64'(b_wdata), 64'(b_rdata));
    chk_rst(2, c_ready, c_rv, c_err, c_en, 64'(c_addr), c_we, c_wdata, c_rdata);
    rst = 1'b0;
    @(negedge clk);
    #1;

    // 32-bit, misaligned accesses split
    issue(0, 1'b0, 3'b000, 32'h100, 64'd0, t);
    pb(0, t + 1, 64'h100, 8'h0, 64'd0); pr(0, t + 2, 1'b0, 64'h80FF1234); wait_done(0);
    issue(0, 1'b0, 3'b001, 32'h102, 64'd0, t);
    pb(0, t + 1, 64'h100, 8'h0, 64'd0); pr(0, t + 2, 1'b0, 64'hFFFF80FF); wait_done(0);
    issue(0, 1'b0, 3'b100, 32'h103, 64'd0, t);
    pb(0, t + 1, 64'h100, 8'h0, 64'd0); pr(0, t + 2, 1'b0, 64'h00000080); wait_done(0);
    issue(0, 1'b0, 3'b011, 32'h103, 64'd0, t);
    pb(0, t + 1, 64'h100, 8'h0, 64'd0); pr(0, t + 2, 1'b0, 64'hFFFFFF80); wait_done(0);
    issue(0, 1'b0, 3'b010, 32'h100, 64'd0, t);
    pb(0, t + 1, 64'h100, 8'h0, 64'd0); pr(0, t + 2, 1'b0, 64'h00001234); wait_done(0);
    issue(0, 1'b0, 3'b001, 32'h101, 64'd0, t);
    pb(0, t + 1, 64'h100, 8'h0, 64'd0); pr(0, t + 2, 1'b0, 64'hFFFFFF12); wait_done(0);
    issue(0, 1'b1, 3'b000, 32'h101, 64'hAABBCCDD, t);
    pb(0, t + 1, 64'h100, 8'b1110, 64'hBBCCDD00);
    pb(0, t + 2, 64'h104, 8'b0001, 64'h000000AA); pr(0, t + 3, 1'b0, 64'd0); wait_done(0);
    issue(0, 1'b0, 3'b000, 32'h101, 64'd0, t);
    pb(0, t + 1, 64'h100, 8'h0, 64'd0); pb(0, t + 2, 64'h104, 8'h0, 64'd0);
    pr(0, t + 3, 1'b0, 64'hAABBCCDD); wait_done(0);
    issue(0, 1'b1, 3'b001, 32'h106, 64'h5678, t);
    pb(0, t + 1, 64'h104, 8'b1100, 64'h56780000); pr(0, t + 2, 1'b0, 64'd0); wait_done(0);
    issue(0, 1'b1, 3'b100, 32'h107, 64'hEE, t);
    pb(0, t + 1, 64'h104, 8'b1000, 64'hEE000000); pr(0, t + 2, 1'b0, 64'd0); wait_done(0);
    issue(0, 1'b0, 3'b010, 32'h107, 64'd0, t);
    pb(0, t + 1, 64'h104, 8'h0, 64'd0); pb(0, t + 2, 64'h108, 8'h0, 64'd0);
    pr(0, t + 3, 1'b0, 64'h000000EE); wait_done(0);
    issue(0, 1'b1, 3'b000, 32'hFFFFFFFE, 64'h11223344, t);
    pb(0, t + 1, 64'hFFFFFFFC, 8'b1100, 64'h33440000);
    pb(0, t + 2, 64'h0, 8'b0011, 64'h00001122); pr(0, t + 3, 1'b0, 64'd0); wait_done(0);
    issue(0, 1'b0, 3'b000, 32'hFFFFFFFE, 64'd0, t);
    pb(0, t + 1, 64'hFFFFFFFC, 8'h0, 64'd0); pb(0, t + 2, 64'h0, 8'h0, 64'd0);
    pr(0, t + 3, 1'b0, 64'h11223344); wait_done(0);
    issue(0, 1'b0, 3'b111, 32'h100, 64'd0, t);
    pr(0, t + 1, 1'b1, 64'd0); wait_done(0);
    issue(0, 1'b0, 3'b101, 32'h100, 64'd0, t);
    pr(0, t + 1, 1'b1, 64'd0); wait_done(0);

    // 32-bit, misaligned accesses rejected
    issue(1, 1'b1, 3'b000, 32'h101, 64'hAABBCCDD, t);
    pr(1, t + 1, 1'b1, 64'd0); wait_done(1);
    issue(1, 1'b0, 3'b111, 32'h100, 64'd0, t);
    pr(1, t + 1, 1'b1, 64'd0); wait_done(1);
    issue(1, 1'b0, 3'b001, 32'h102, 64'd0, t);
    pb(1, t + 1, 64'h100, 8'h0, 64'd0); pr(1, t + 2, 1'b0, 64'hFFFFBBCC); wait_done(1);
    issue(1, 1'b0, 3'b010, 32'h101, 64'd0, t);
    pr(1, t + 1, 1'b1, 64'd0); wait_done(1);
    issue(1, 1'b0, 3'b100, 32'h103, 64'd0, t);
    pb(1, t + 1, 64'h100, 8'h0, 64'd0); pr(1, t + 2, 1'b0, 64'h000000BB); wait_done(1);

    // 64-bit
    issue(2, 1'b0, 3'b101, 32'h8, 64'd0, t);
    pb(2, t + 1, 64'h8, 8'h0, 64'd0); pr(2, t + 2, 1'b0, 64'h1716151413121110); wait_done(2);
    issue(2, 1'b0, 3'b101, 32'hC, 64'd0, t);
    pb(2, t + 1, 64'h8, 8'h0, 64'd0); pb(2, t + 2, 64'h10, 8'h0, 64'd0);
    pr(2, t + 3, 1'b0, 64'h1B1A191817161514); wait_done(2);
    issue(2, 1'b0, 3'b000, 32'hC, 64'd0, t);
    pb(2, t + 1, 64'h8, 8'h0, 64'd0); pr(2, t + 2, 1'b0, 64'h17161514); wait_done(2);
    issue(2, 1'b1, 3'b101, 32'h13, 64'h8877665544332211, t);
    pb(2, t + 1, 64'h10, 8'hF8, 64'h5544332211887766);
    pb(2, t + 2, 64'h18, 8'h07, 64'h5544332211887766); pr(2, t + 3, 1'b0, 64'd0); wait_done(2);
    issue(2, 1'b0, 3'b001, 32'h16, 64'd0, t);
    pb(2, t + 1, 64'h10, 8'h0, 64'd0); pr(2, t + 2, 1'b0, 64'h5544); wait_done(2);
    issue(2, 1'b0, 3'b011, 32'h1A, 64'd0, t);
    pb(2, t + 1, 64'h18, 8'h0, 64'd0); pr(2, t + 2, 1'b0, 64'hFFFFFFFFFFFFFF88); wait_done(2);

    // Reset during the second beat of a split store: no response may follow
    issue(0, 1'b1, 3'b000, 32'h201, 64'h12345678, t);
    pb(0, t + 1, 64'h200, 8'b1110, 64'h34567800);
    @(posedge clk);
    #1;
    check(0, "acc1_mem_en", 64'(a_en), 64'd1);
    check(0, "acc1_mem_we", 64'(a_we), 64'b0001);
    rst = 1'b1;
    #1;
    check(0, "rst_mid_mem_en", 64'(a_en), 64'd0);
    check(0, "rst_mid_mem_we", 64'(a_we), 64'd0);
    check(0, "rst_mid_resp_valid", 64'(a_rv), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check(0, "post_rst_ready", 64'(a_ready), 64'd1);
    repeat (5) @(negedge clk);
    #1;
    check(0, "post_rst_beats_left", 64'(exp_beat[0].size()), 64'd0);
    check(0, "post_rst_ready_idle", 64'(a_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
